microcontrolador_nios2_cpu_debug_host_shifter: RTL and testbench

MICROCONTROLADOR_NIOS2_CPU_DEBUG_HOST_SHIFTER -- requirements
Module: microcontrolador_nios2_cpu_debug_host_shifter

---
 rtl/microcontrolador_nios2_cpu_debug_host_shifter.sv | 146 ++++++++++++++
 tb/tb_microcontrolador_nios2_cpu_debug_host_shifter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcontrolador_nios2_cpu_debug_host_shifter.sv
// Virtual JTAG debug host: runs one IR-update / DR-scan cycle per command and returns the captured DR.
// Optional build macro DEBUG_HOST_IR_SKIP_EN skips UIR when the requested IR is already loaded.
module microcontrolador_nios2_cpu_debug_host_shifter #(
    parameter int TCK_HALF = 2,
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                vjh_tck,
    output logic                vjh_tdi,
    input  logic                vjh_tdo,
    output logic [IR_WIDTH-1:0] vjh_ir_in,
    output logic                vjh_uir,
    output logic                vjh_cdr,
    output logic                vjh_sdr,
    output logic                vjh_udr,
    output logic                vjh_rti
);

    localparam int PERIOD = 2 * TCK_HALF;
    localparam int PH_W   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int BIT_W  = (DR_WIDTH > 1) ? $clog2(DR_WIDTH + 1) : 1;

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_RISE = PH_W'(TCK_HALF - 1);
    localparam logic [PH_W-1:0]  PH_HIGH = PH_W'(TCK_HALF);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        RTI,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [BIT_W-1:0]    bitCnt_q, bitCnt_d;
    logic [DR_WIDTH-1:0] shift_q, shift_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                tdoBit_q, tdoBit_d;
    logic                irDone_q, irDone_d;

    logic accept;
    logic periodEnd;
    logic active;
    logic skipIr;

    assign accept    = cmd_valid && (state_q == IDLE);
    assign periodEnd = (phase_q == PH_LAST);
    assign active    = (state_q != IDLE) && (state_q != RESP);

`ifdef DEBUG_HOST_IR_SKIP_EN
    assign skipIr = irDone_q && (cmd_ir == ir_q);
`else
    assign skipIr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_valid) state_d = skipIr ? CDR : UIR;
            UIR:  if (periodEnd) state_d = CDR;
            CDR:  if (periodEnd) state_d = SDR;
            SDR:  if (periodEnd && (bitCnt_q == BIT_LAST)) state_d = UDR;
            UDR:  if (periodEnd) state_d = RTI;
            RTI:  if (periodEnd) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tdo is captured on the tck rising edge and only merged into the shifter at period end
    always_comb begin
        phase_d  = '0;
        bitCnt_d = '0;
        tdoBit_d = tdoBit_q;
        shift_d  = shift_q;
        ir_d     = ir_q;
        irDone_d = irDone_q;

        if (active && !periodEnd) begin
            phase_d = phase_q + 1'b1;
        end
        if (state_q == SDR) begin
            bitCnt_d = periodEnd ? bitCnt_q + 1'b1 : bitCnt_q;
            if (phase_q == PH_RISE) begin
                tdoBit_d = vjh_tdo;
            end
            if (periodEnd) begin
                shift_d = {tdoBit_q, shift_q[DR_WIDTH-1:1]};
            end
        end
        if (accept) begin
            shift_d = cmd_dr;
            ir_d    = cmd_ir;
        end
        if ((state_q == UIR) && periodEnd) begin
            irDone_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            bitCnt_q <= '0;
            shift_q  <= '0;
            ir_q     <= '0;
            tdoBit_q <= 1'b0;
            irDone_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            ir_q     <= ir_d;
            tdoBit_q <= tdoBit_d;
            irDone_q <= irDone_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_dr    = shift_q;
    assign vjh_ir_in = ir_q;
    assign vjh_tck   = active && (phase_q >= PH_HIGH);
    assign vjh_tdi   = (state_q == SDR) && shift_q[0];
    assign vjh_uir   = (state_q == UIR);
    assign vjh_cdr   = (state_q == CDR);
    assign vjh_sdr   = (state_q == SDR);
    assign vjh_udr   = (state_q == UDR);
    assign vjh_rti   = (state_q == RTI);

endmodule

// File: tb/tb_microcontrolador_nios2_cpu_debug_host_shifter.sv
// Scoreboard bench for the debug host shifter: directed commands push expectations, a negedge monitor checks responses.
module tb_microcontrolador_nios2_cpu_debug_host_shifter;

    localparam int TCK_HALF = 2;
    localparam int DR_WIDTH = 38;
    localparam int IR_WIDTH = 2;
    localparam int LAT_FULL = 168;
    localparam int LAT_SKIP = 164;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir = '0;
    logic [DR_WIDTH-1:0] cmd_dr = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic                vjh_tck;
    logic                vjh_tdi;
    logic                vjh_tdo;
    logic [IR_WIDTH-1:0] vjh_ir_in;
    logic                vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, vjh_rti;

    logic [1:0] tdoMode = 2'd0;
    assign vjh_tdo = (tdoMode == 2'd0) ? vjh_tdi : (tdoMode == 2'd1);

    microcontrolador_nios2_cpu_debug_host_shifter #(
        .TCK_HALF(TCK_HALF),
        .DR_WIDTH(DR_WIDTH),
        .IR_WIDTH(IR_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir),
        .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr),
        .vjh_tck(vjh_tck),
        .vjh_tdi(vjh_tdi),
        .vjh_tdo(vjh_tdo),
        .vjh_ir_in(vjh_ir_in),
        .vjh_uir(vjh_uir),
        .vjh_cdr(vjh_cdr),
        .vjh_sdr(vjh_sdr),
        .vjh_udr(vjh_udr),
        .vjh_rti(vjh_rti)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DR_WIDTH-1:0] dr;
        logic [IR_WIDTH-1:0] ir;
        int                  lat;
    } exp_t;

    exp_t expQ[$];

    int   compared = 0;
    int   mismatched = 0;
    int   cycleCnt = 0;
    int   acceptCycle = 0;
    int   tckSdrRises = 0;
    int   uirPulses = 0;
    int   violations = 0;
    bit   rspSeen = 1'b0;
    logic prevTck = 1'b0;
    logic prevUir = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(posedge clk) cycleCnt++;

    // Monitor: tracks acceptance time, protocol invariants, and scores every new response
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (cmd_valid && cmd_ready) acceptCycle = cycleCnt + 1;
            if (($countones({vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, vjh_rti}) > 1) ||
                (vjh_tdi && !vjh_sdr) || (vjh_tck && (cmd_ready || rsp_valid)))
                violations++;
            if (vjh_tck && !prevTck && vjh_sdr) tckSdrRises++;
            if (vjh_uir && !prevUir) uirPulses++;
        end
        prevTck = vjh_tck;
        prevUir = vjh_uir;
        if (rsp_valid && !rspSeen) begin
            rspSeen = 1'b1;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rsp", 64'(rsp_dr), 64'd0 - 64'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("rsp_dr", 64'(rsp_dr), 64'(e.dr));
                checkOutput("rsp_latency", 64'(cycleCnt - acceptCycle), 64'(e.lat));
                checkOutput("ir_in", 64'(vjh_ir_in), 64'(e.ir));
            end
        end else if (!rsp_valid) begin
            rspSeen = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [IR_WIDTH-1:0] ir, input logic [DR_WIDTH-1:0] dr,
                                 input logic [DR_WIDTH-1:0] expDr, input int expLat, input bit push);
        exp_t e;
        int guard = 0;
        while (!cmd_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", 64'd0, 64'd1);
            return;
        end
        if (push) begin
            e.dr = expDr;
            e.ir = ir;
            e.lat = expLat;
            expQ.push_back(e);
        end
        cmd_ir = ir;
        cmd_dr = dr;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitResponse();
        int guard = 0;
        while (!rsp_valid && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!rsp_valid) checkOutput("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic releaseResponse();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("idle_after_rsp", 64'(cmd_ready), 64'd1);
    endtask

    function automatic logic [63:0] outVector();
        return 64'({cmd_ready, rsp_valid, vjh_tck, vjh_tdi, vjh_uir, vjh_cdr, vjh_sdr,
                    vjh_udr, vjh_rti, vjh_ir_in, rsp_dr});
    endfunction

    localparam logic [63:0] RESET_VEC = 64'({1'b1, 8'b0, 2'b0, 38'b0});

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int snap;
        int bad;
        logic [DR_WIDTH-1:0] held;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", outVector(), RESET_VEC);
        reset = 1'b0;

        tdoMode = 2'd0;
        applyStimulus(2'b01, 38'h2A_5555_5555, 38'h2A_5555_5555, LAT_FULL, 1'b1);
        waitResponse();
        releaseResponse();

        tdoMode = 2'd1;
        snap = tckSdrRises;
        applyStimulus(2'b01, 38'h12_3456_789A, 38'h3F_FFFF_FFFF, LAT_FULL, 1'b1);
        waitResponse();
        checkOutput("sdr_tck_rises", 64'(tckSdrRises - snap), 64'd38);
        releaseResponse();

        tdoMode = 2'd2;
        applyStimulus(2'b10, 38'h3F_0F0F_0F0F, 38'h00_0000_0000, LAT_FULL, 1'b1);
        waitResponse();
        releaseResponse();

        tdoMode = 2'd0;
        held = 38'h15_A5C3_3C5A;
        applyStimulus(2'b01, held, held, LAT_FULL, 1'b1);
        waitResponse();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                cmd_ir = 2'b11;
                cmd_dr = 38'h01_2345_6789;
                cmd_valid = 1'b1;
            end
            if (i == 4) cmd_valid = 1'b0;
            checkOutput("rsp_hold", 64'({rsp_valid, cmd_ready, rsp_dr}), 64'({1'b1, 1'b0, held}));
        end
        releaseResponse();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (vjh_uir || !cmd_ready) bad++;
        end
        checkOutput("ignored_cmd_not_queued", 64'(bad), 64'd0);

        tdoMode = 2'd0;
        snap = tckSdrRises;
        applyStimulus(2'b11, 38'h0A_BCDE_F012, 38'h0A_BCDE_F012, LAT_FULL, 1'b0);
        bad = 0;
        while ((tckSdrRises - snap) < 20 && bad < 1000) begin
            @(posedge clk); #1;
            bad++;
        end
        checkOutput("reached_bit20", 64'(vjh_sdr), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_reset_state", outVector(), RESET_VEC);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(2'b11, 38'h0A_BCDE_F012, 38'h0A_BCDE_F012, LAT_FULL, 1'b1);
        waitResponse();
        releaseResponse();

        snap = uirPulses;
        applyStimulus(2'b10, 38'h33_CCCC_3333, 38'h33_CCCC_3333, LAT_FULL, 1'b1);
        waitResponse();
        checkOutput("uir_first_10", 64'(uirPulses - snap), 64'd1);
        releaseResponse();

        snap = uirPulses;
`ifdef DEBUG_HOST_IR_SKIP_EN
        applyStimulus(2'b10, 38'h00_FFFF_0001, 38'h00_FFFF_0001, LAT_SKIP, 1'b1);
        waitResponse();
        checkOutput("uir_second_10", 64'(uirPulses - snap), 64'd0);
`else
        applyStimulus(2'b10, 38'h00_FFFF_0001, 38'h00_FFFF_0001, LAT_FULL, 1'b1);
        waitResponse();
        checkOutput("uir_second_10", 64'(uirPulses - snap), 64'd1);
`endif
        releaseResponse();

        snap = uirPulses;
        applyStimulus(2'b11, 38'h2B_DEAD_BEEF, 38'h2B_DEAD_BEEF, LAT_FULL, 1'b1);
        waitResponse();
        checkOutput("uir_third_11", 64'(uirPulses - snap), 64'd1);
        releaseResponse();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("protocol_violations", 64'(violations), 64'd0);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
